// File: rtl/mnacidpro_valve_seq_if.sv
// -----------------------------------------------------------------------------
// mnacidpro_valve_seq_if
// Command channel between host command logic and the valve sequencer.
//   cmd_valid     host -> seq   command present
//   cmd_ready     seq  -> host  command accepted when cmd_valid & cmd_ready
//   cmd_open      host -> seq   route mask, bit i-1 = 1 opens valve vi
//   cmd_pump_n    host -> seq   pump cycles to run (0 = no pumping)
//   cmd_pump_rev  host -> seq   1 = reverse pump direction
// Modports: master (host side), slave (sequencer side).
// -----------------------------------------------------------------------------
interface mnacidpro_valve_seq_if #(
   parameter int unsigned CNT_W = 16
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [12:0]      cmd_open;
   logic [CNT_W-1:0] cmd_pump_n;
   logic             cmd_pump_rev;

   modport master (
      output cmd_valid, cmd_open, cmd_pump_n, cmd_pump_rev,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_open, cmd_pump_n, cmd_pump_rev,
      output cmd_ready
   );
endinterface

// File: rtl/mnacidpro_valve_seq.sv
// -----------------------------------------------------------------------------
// mnacidpro_valve_seq
// Clocked sequencer for the mnacidpro valve network. Runs one transfer at a
// time: OPEN (route valves open, settle) -> PUMP (6-phase peristaltic ring,
// N cycles) -> CLOSE (everything pressurised, settle) -> DONE (1-cycle pulse).
//
// Parameters:
//   SETTLE_CYC  cycles held in OPEN and in CLOSE (>=1)
//   PHASE_CYC   cycles per pump phase (>=1)
//   CNT_W       width of the pump-cycle count
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   cmd           command channel (slave modport of mnacidpro_valve_seq_if)
//   abort         terminate the active transfer (OPEN/PUMP only)
//   valve_c[12:0] bit i-1 drives ci; 1 = pressurised/closed
//   pump_p[2:0]   {p3,p2,p1}; 1 = closed
//   busy          state != IDLE
//   done          1-cycle pulse at end of transfer
//   done_aborted  qualified by done; transfer ended by abort/interlock
// Build option:
//   MNACIDPRO_INTERLOCK_EN  reject masks opening >1 of v1..v3 or both v12,v13;
//                           such a command completes the handshake and goes
//                           straight to DONE with done_aborted = 1.
// -----------------------------------------------------------------------------
module mnacidpro_valve_seq #(
   parameter int unsigned SETTLE_CYC = 16,
   parameter int unsigned PHASE_CYC  = 32,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   mnacidpro_valve_seq_if.slave   cmd,
   input  logic                   abort,
   output logic [12:0]            valve_c,
   output logic [2:0]             pump_p,
   output logic                   busy,
   output logic                   done,
   output logic                   done_aborted
);

   localparam int unsigned TMAX = (SETTLE_CYC > PHASE_CYC) ? SETTLE_CYC : PHASE_CYC;
   localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   typedef enum logic [2:0] {
      IDLE,
      OPEN,
      PUMP,
      CLOSE,
      DONE
   } state_t;

   state_t           state;
   logic [TW-1:0]    tcnt;        // cycles spent in the current OPEN/CLOSE/phase
   logic [2:0]       ph;          // current pump phase S0..S5
   logic [CNT_W-1:0] cyc_left;    // pump cycles still to run, including current
   logic             rev;
   logic             aborted;

   logic             cmd_illegal;
   logic [2:0]       ph_next;
   logic             ph_wrap;
   logic             settle_end;
   logic             phase_end;

   function automatic logic [2:0] phase_pat(input logic [2:0] p);
      case (p)
         3'd0:    phase_pat = 3'b110;
         3'd1:    phase_pat = 3'b100;
         3'd2:    phase_pat = 3'b101;
         3'd3:    phase_pat = 3'b001;
         3'd4:    phase_pat = 3'b011;
         3'd5:    phase_pat = 3'b010;
         default: phase_pat = 3'b111;
      endcase
   endfunction

`ifdef MNACIDPRO_INTERLOCK_EN
   assign cmd_illegal = ($countones(cmd.cmd_open[2:0]) > 1) ||
                        (cmd.cmd_open[11] && cmd.cmd_open[12]);
`else
   assign cmd_illegal = 1'b0;
`endif

   assign cmd.cmd_ready = (state == IDLE) && !abort;

   assign settle_end = (tcnt == TW'(SETTLE_CYC - 1));
   assign phase_end  = (tcnt == TW'(PHASE_CYC - 1));

   // Ring stepping: a pump cycle completes on the step back into S0,
   // which comes from S5 going forward and from S1 going in reverse.
   always_comb begin
      ph_next = ph;
      ph_wrap = 1'b0;
      if (rev) begin
         ph_next = (ph == 3'd0) ? 3'd5 : ph - 3'd1;
         ph_wrap = (ph == 3'd1);
      end else begin
         ph_next = (ph == 3'd5) ? 3'd0 : ph + 3'd1;
         ph_wrap = (ph == 3'd5);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         tcnt         <= '0;
         ph           <= '0;
         cyc_left     <= '0;
         rev          <= 1'b0;
         aborted      <= 1'b0;
         valve_c      <= '1;
         pump_p       <= '1;
         busy         <= 1'b0;
         done         <= 1'b0;
         done_aborted <= 1'b0;
      end else begin
         done         <= 1'b0;
         done_aborted <= 1'b0;

         case (state)
            IDLE: begin
               if (cmd.cmd_valid && !abort) begin
                  tcnt     <= '0;
                  ph       <= '0;
                  cyc_left <= cmd.cmd_pump_n;
                  rev      <= cmd.cmd_pump_rev;
                  busy     <= 1'b1;
                  if (cmd_illegal) begin
                     // Rejected route: valves never move, report as aborted.
                     state        <= DONE;
                     aborted      <= 1'b1;
                     done         <= 1'b1;
                     done_aborted <= 1'b1;
                  end else begin
                     state   <= OPEN;
                     aborted <= 1'b0;
                     valve_c <= ~cmd.cmd_open;
                     pump_p  <= '1;
                  end
               end
            end

            OPEN: begin
               if (abort) begin
                  state   <= CLOSE;
                  aborted <= 1'b1;
                  tcnt    <= '0;
                  valve_c <= '1;
                  pump_p  <= '1;
               end else if (settle_end) begin
                  tcnt <= '0;
                  if (cyc_left != '0) begin
                     state  <= PUMP;
                     ph     <= 3'd0;
                     pump_p <= phase_pat(3'd0);
                  end else begin
                     state   <= CLOSE;
                     valve_c <= '1;
                     pump_p  <= '1;
                  end
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end

            PUMP: begin
               if (abort) begin
                  state   <= CLOSE;
                  aborted <= 1'b1;
                  tcnt    <= '0;
                  valve_c <= '1;
                  pump_p  <= '1;
               end else if (phase_end) begin
                  tcnt <= '0;
                  // Terminal compare on the last cycle avoids decrementing
                  // past zero, so an all-ones count runs in full.
                  if (ph_wrap && (cyc_left == CNT_W'(1))) begin
                     state   <= CLOSE;
                     valve_c <= '1;
                     pump_p  <= '1;
                  end else begin
                     if (ph_wrap)
                        cyc_left <= cyc_left - CNT_W'(1);
                     ph     <= ph_next;
                     pump_p <= phase_pat(ph_next);
                  end
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end

            CLOSE: begin
               if (settle_end) begin
                  state        <= DONE;
                  tcnt         <= '0;
                  done         <= 1'b1;
                  done_aborted <= aborted;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end

            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               valve_c <= '1;
               pump_p  <= '1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mnacidpro_valve_seq.sv
// -----------------------------------------------------------------------------
// tb_mnacidpro_valve_seq
// Directed bench for mnacidpro_valve_seq with SETTLE_CYC=4, PHASE_CYC=2.
// Sample index k counts negedges after the accepting posedge (k=0 is the
// first OPEN cycle). Each compared vector is
//   {valve_c[12:0], pump_p[2:0], busy, done, done_aborted, cmd_ready}.
// -----------------------------------------------------------------------------
module tb_mnacidpro_valve_seq;

   localparam int unsigned CNT_W = 16;

   logic        clk;
   logic        rst;
   logic        abort;
   logic [12:0] valve_c;
   logic [2:0]  pump_p;
   logic        busy;
   logic        done;
   logic        done_aborted;

   int errors;
   int checks;

   mnacidpro_valve_seq_if #(.CNT_W(CNT_W)) cif ();

   mnacidpro_valve_seq #(
      .SETTLE_CYC (4),
      .PHASE_CYC  (2),
      .CNT_W      (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd          (cif),
      .abort        (abort),
      .valve_c      (valve_c),
      .pump_p       (pump_p),
      .busy         (busy),
      .done         (done),
      .done_aborted (done_aborted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [19:0] IDLE_VEC = {13'h1FFF, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1};

   function automatic logic [19:0] observed();
      observed = {valve_c, pump_p, busy, done, done_aborted, cif.cmd_ready};
   endfunction

   function automatic logic [2:0] fwd_pat(input int pos);
      case (pos)
         0: fwd_pat = 3'b110;
         1: fwd_pat = 3'b100;
         2: fwd_pat = 3'b101;
         3: fwd_pat = 3'b001;
         4: fwd_pat = 3'b011;
         default: fwd_pat = 3'b010;
      endcase
   endfunction

   function automatic logic [2:0] rev_pat(input int pos);
      case (pos)
         0: rev_pat = 3'b110;
         1: rev_pat = 3'b010;
         2: rev_pat = 3'b011;
         3: rev_pat = 3'b001;
         4: rev_pat = 3'b101;
         default: rev_pat = 3'b100;
      endcase
   endfunction

   // Expected vector for an uninterrupted transfer at sample k.
   function automatic logic [19:0] model(input int k, input logic [12:0] open,
                                          input int n, input bit rv);
      int          total;
      int          pos;
      logic [12:0] v;
      logic [2:0]  p;
      logic        b, d, r;
      total = 8 + 12 * n;
      v = 13'h1FFF; p = 3'b111; b = 1'b1; d = 1'b0; r = 1'b0;
      if (k < 4) begin
         v = ~open;
      end else if (k < 4 + 12 * n) begin
         v   = ~open;
         pos = ((k - 4) / 2) % 6;
         p   = rv ? rev_pat(pos) : fwd_pat(pos);
      end else if (k == total) begin
         d = 1'b1;
      end else if (k > total) begin
         b = 1'b0;
         r = 1'b1;
      end
      model = {v, p, b, d, 1'b0, r};
   endfunction

   // Expected vector when abort is held during sample ka (OPEN or PUMP).
   function automatic logic [19:0] model_abort(input int k, input logic [12:0] open,
                                                input int n, input bit rv, input int ka);
      if (k <= ka)
         model_abort = model(k, open, n, rv);
      else if (k <= ka + 4)
         model_abort = {13'h1FFF, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0};
      else if (k == ka + 5)
         model_abort = {13'h1FFF, 3'b111, 1'b1, 1'b1, 1'b1, 1'b0};
      else
         model_abort = IDLE_VEC;
   endfunction

   // Called at a negedge while idle; returns at the negedge of sample k=0.
   task automatic send_cmd(input logic [12:0] open, input int n, input bit rv);
      cif.cmd_valid    = 1'b1;
      cif.cmd_open     = open;
      cif.cmd_pump_n   = CNT_W'(n);
      cif.cmd_pump_rev = rv;
      @(negedge clk);
      cif.cmd_valid    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (observed() !== IDLE_VEC) begin
         errors++;
         $display("FAIL reset_hold: got %h want %h", observed(), IDLE_VEC);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (observed() !== IDLE_VEC) begin
         errors++;
         $display("FAIL reset_release: got %h want %h", observed(), IDLE_VEC);
      end
   endtask

   task automatic test_forward();
      logic [19:0] exp_v;
      send_cmd(13'h0809, 2, 1'b0);
      for (int k = 0; k <= 33; k++) begin
         exp_v = model(k, 13'h0809, 2, 1'b0);
         checks++;
         if (observed() !== exp_v) begin
            errors++;
            $display("FAIL forward k=%0d: got %h want %h", k, observed(), exp_v);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reverse();
      logic [19:0] exp_v;
      send_cmd(13'h0012, 1, 1'b1);
      for (int k = 0; k <= 21; k++) begin
         exp_v = model(k, 13'h0012, 1, 1'b1);
         checks++;
         if (observed() !== exp_v) begin
            errors++;
            $display("FAIL reverse k=%0d: got %h want %h", k, observed(), exp_v);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_no_pump();
      logic [19:0] exp_v;
      send_cmd(13'h0104, 0, 1'b0);
      for (int k = 0; k <= 9; k++) begin
         exp_v = model(k, 13'h0104, 0, 1'b0);
         checks++;
         if (observed() !== exp_v) begin
            errors++;
            $display("FAIL no_pump k=%0d: got %h want %h", k, observed(), exp_v);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_abort_pump();
      logic [19:0] exp_v;
      send_cmd(13'h0809, 2, 1'b0);
      for (int k = 0; k <= 12; k++) begin
         exp_v = model_abort(k, 13'h0809, 2, 1'b0, 6);
         checks++;
         if (observed() !== exp_v) begin
            errors++;
            $display("FAIL abort_pump k=%0d: got %h want %h", k, observed(), exp_v);
         end
         if (k == 6) abort = 1'b1;
         if (k == 7) abort = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_abort_open();
      logic [19:0] exp_v;
      send_cmd(13'h0040, 3, 1'b1);
      for (int k = 0; k <= 7; k++) begin
         exp_v = model_abort(k, 13'h0040, 3, 1'b1, 1);
         checks++;
         if (observed() !== exp_v) begin
            errors++;
            $display("FAIL abort_open k=%0d: got %h want %h", k, observed(), exp_v);
         end
         if (k == 1) abort = 1'b1;
         if (k == 2) abort = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_abort_close_ignored();
      logic [19:0] exp_v;
      send_cmd(13'h0400, 0, 1'b0);
      for (int k = 0; k <= 9; k++) begin
         exp_v = model(k, 13'h0400, 0, 1'b0);
         checks++;
         if (observed() !== exp_v) begin
            errors++;
            $display("FAIL abort_close k=%0d: got %h want %h", k, observed(), exp_v);
         end
         if (k == 5) abort = 1'b1;
         if (k == 8) abort = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_abort_idle();
      abort            = 1'b1;
      cif.cmd_valid    = 1'b1;
      cif.cmd_open     = 13'h0001;
      cif.cmd_pump_n   = CNT_W'(1);
      cif.cmd_pump_rev = 1'b0;
      #1;
      checks++;
      if (cif.cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle_ready: got %b want 0", cif.cmd_ready);
      end
      @(negedge clk);
      checks++;
      if (observed() !== {13'h1FFF, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL abort_idle_noaccept: got %h want %h", observed(),
                  {13'h1FFF, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0});
      end
      cif.cmd_valid = 1'b0;
      abort         = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_pump();
      logic [19:0] exp_v;
      send_cmd(13'h0809, 3, 1'b0);
      for (int k = 0; k <= 9; k++) begin
         exp_v = model(k, 13'h0809, 3, 1'b0);
         checks++;
         if (observed() !== exp_v) begin
            errors++;
            $display("FAIL rst_mid_pre k=%0d: got %h want %h", k, observed(), exp_v);
         end
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int j = 0; j < 5; j++) begin
         checks++;
         if (observed() !== IDLE_VEC) begin
            errors++;
            $display("FAIL rst_mid_post j=%0d: got %h want %h", j, observed(), IDLE_VEC);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [19:0] exp_v;
      send_cmd(13'h0003, 0, 1'b0);
      for (int k = 0; k <= 9; k++) begin
         exp_v = model(k, 13'h0003, 0, 1'b0);
         checks++;
         if (observed() !== exp_v) begin
            errors++;
            $display("FAIL b2b_first k=%0d: got %h want %h", k, observed(), exp_v);
         end
         // Hold the next command early; it must not be taken before IDLE.
         if (k == 7) begin
            cif.cmd_valid    = 1'b1;
            cif.cmd_open     = 13'h1010;
            cif.cmd_pump_n   = CNT_W'(1);
            cif.cmd_pump_rev = 1'b0;
         end
         @(negedge clk);
      end
      cif.cmd_valid = 1'b0;
      for (int k = 0; k <= 21; k++) begin
         exp_v = model(k, 13'h1010, 1, 1'b0);
         checks++;
         if (observed() !== exp_v) begin
            errors++;
            $display("FAIL b2b_second k=%0d: got %h want %h", k, observed(), exp_v);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_interlock();
      logic [19:0] exp_v;
      send_cmd(13'h1800, 1, 1'b0);
`ifdef MNACIDPRO_INTERLOCK_EN
      for (int k = 0; k <= 2; k++) begin
         if (k == 0)
            exp_v = {13'h1FFF, 3'b111, 1'b1, 1'b1, 1'b1, 1'b0};
         else
            exp_v = IDLE_VEC;
         checks++;
         if (observed() !== exp_v) begin
            errors++;
            $display("FAIL interlock k=%0d: got %h want %h", k, observed(), exp_v);
         end
         @(negedge clk);
      end
`else
      for (int k = 0; k <= 21; k++) begin
         exp_v = model(k, 13'h1800, 1, 1'b0);
         checks++;
         if (observed() !== exp_v) begin
            errors++;
            $display("FAIL interlock_off k=%0d: got %h want %h", k, observed(), exp_v);
         end
         @(negedge clk);
      end
`endif
   endtask

   initial begin
      errors           = 0;
      checks           = 0;
      rst              = 1'b1;
      abort            = 1'b0;
      cif.cmd_valid    = 1'b0;
      cif.cmd_open     = '0;
      cif.cmd_pump_n   = '0;
      cif.cmd_pump_rev = 1'b0;
      @(negedge clk);

      test_reset();
      test_forward();
      test_reverse();
      test_no_pump();
      test_abort_pump();
      test_abort_open();
      test_abort_close_ignored();
      test_abort_idle();
      test_reset_mid_pump();
      test_back_to_back();
      test_interlock();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
